// File: rtl/game_timer_bank.sv
// Bank of CHANNELS countdown timers paced by one shared frame-tick prescaler.
// Optional macro GAME_TIMER_PAUSE_EN adds a pause input that freezes the prescaler.
module game_timer_bank #(
  parameter int CLK_HZ   = 50000000,
  parameter int TICK_HZ  = 60,
  parameter int CHANNELS = 4,
  parameter int CNT_W    = 16
) (
  input  logic                      clk,
  input  logic                      resetn,
`ifdef GAME_TIMER_PAUSE_EN
  input  logic                      pause,
`endif
  output logic                      frame_tick,
  input  logic [CHANNELS-1:0]       start,
  input  logic [CHANNELS-1:0]       stop,
  input  logic [CHANNELS-1:0]       clear,
  input  logic [CHANNELS-1:0]       periodic,
  input  logic [CHANNELS*CNT_W-1:0] load_val,
  output logic [CHANNELS-1:0]       busy,
  output logic [CHANNELS-1:0]       timeout,
  output logic [CHANNELS*CNT_W-1:0] remaining
);

  localparam int            DIV       = CLK_HZ / TICK_HZ;
  localparam int            PW        = $clog2(DIV);
  localparam logic [PW-1:0] PRESC_MAX = PW'(DIV - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  logic hold;
`ifdef GAME_TIMER_PAUSE_EN
  assign hold = pause;
`else
  assign hold = 1'b0;
`endif

  // Stage p0: prescaler; a held prescaler keeps its phase and suppresses the tick
  logic [PW-1:0] presc_p0;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      presc_p0   <= '0;
      frame_tick <= 1'b0;
    end else if (hold) begin
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= (presc_p0 == PRESC_MAX);
      presc_p0   <= (presc_p0 == PRESC_MAX) ? '0 : presc_p0 + 1'b1;
    end
  end

  // Stage p1: per-channel countdown, priority clear > start > stop > tick
  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    state_t           state_p1, state_nxt;
    logic [CNT_W-1:0] cnt_p1, cnt_nxt, lv;
    logic             to_p1, to_nxt;

    assign lv = load_val[i*CNT_W +: CNT_W];

    always_comb begin
      state_nxt = state_p1;
      cnt_nxt   = cnt_p1;
      to_nxt    = 1'b0;
      if (clear[i]) begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end else if (start[i]) begin
        if (lv != '0) begin
          state_nxt = RUN;
          cnt_nxt   = lv;
        end else begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
          to_nxt    = 1'b1;
        end
      end else if (stop[i]) begin
        state_nxt = IDLE;
      end else if (state_p1 == RUN && frame_tick) begin
        if (cnt_p1 > CNT_W'(1)) begin
          cnt_nxt = cnt_p1 - 1'b1;
        end else begin
          to_nxt = 1'b1;
          // A zero reload length ends a periodic channel instead of spinning
          if (periodic[i] && lv != '0) begin
            cnt_nxt = lv;
          end else begin
            cnt_nxt   = '0;
            state_nxt = IDLE;
          end
        end
      end
    end

    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        state_p1 <= IDLE;
        cnt_p1   <= '0;
        to_p1    <= 1'b0;
      end else begin
        state_p1 <= state_nxt;
        cnt_p1   <= cnt_nxt;
        to_p1    <= to_nxt;
      end
    end

    assign busy[i]                      = (state_p1 == RUN);
    assign timeout[i]                   = to_p1;
    assign remaining[i*CNT_W +: CNT_W]  = cnt_p1;
  end

endmodule

// File: tb/tb_game_timer_bank.sv
// Self-checking bench for game_timer_bank (DIV=10, 2 channels, 8-bit counts) against a behavioural model.
module tb_game_timer_bank;
  localparam int CH = 2;
  localparam int W  = 8;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          frame_tick;
  logic [CH-1:0] start = '0, stop = '0, clear = '0, periodic = '0;
  logic [CH-1:0] busy, timeout;
  logic [CH*W-1:0] load_val = '0, remaining;
`ifdef GAME_TIMER_PAUSE_EN
  logic          pause = 1'b0;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  game_timer_bank #(.CLK_HZ(600), .TICK_HZ(60), .CHANNELS(CH), .CNT_W(W)) dut (
    .clk        (clk),
    .resetn     (resetn),
`ifdef GAME_TIMER_PAUSE_EN
    .pause      (pause),
`endif
    .frame_tick (frame_tick),
    .start      (start),
    .stop       (stop),
    .clear      (clear),
    .periodic   (periodic),
    .load_val   (load_val),
    .busy       (busy),
    .timeout    (timeout),
    .remaining  (remaining)
  );

  logic [20:0] act;
  assign act = {frame_tick, busy, timeout, remaining};

  // Behavioural model: frames counted as unpaused clocks since reset, channels as "ticks left"
  int m_ph = 0;
  bit m_ft = 1'b0;
  int m_rem [CH] = '{default: 0};
  bit m_run [CH] = '{default: 1'b0};
  bit m_to  [CH] = '{default: 1'b0};

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_ph = 0;
      m_ft = 1'b0;
      for (int c = 0; c < CH; c++) begin
        m_rem[c] = 0; m_run[c] = 1'b0; m_to[c] = 1'b0;
      end
    end else begin : m_upd
      bit tick_now;
      bit paused;
      int lv;
      tick_now = m_ft;
      paused = 1'b0;
`ifdef GAME_TIMER_PAUSE_EN
      paused = pause;
`endif
      for (int c = 0; c < CH; c++) begin
        lv = int'(load_val[c*W +: W]);
        m_to[c] = 1'b0;
        if (clear[c]) begin
          m_run[c] = 1'b0; m_rem[c] = 0;
        end else if (start[c]) begin
          m_rem[c] = lv;
          m_run[c] = (lv != 0);
          m_to[c]  = (lv == 0);
        end else if (stop[c]) begin
          m_run[c] = 1'b0;
        end else if (m_run[c] && tick_now) begin
          m_rem[c] = m_rem[c] - 1;
          if (m_rem[c] == 0) begin
            m_to[c] = 1'b1;
            if (periodic[c] && lv != 0) m_rem[c] = lv;
            else m_run[c] = 1'b0;
          end
        end
      end
      m_ft = !paused && (m_ph % 10 == 9);
      if (!paused) m_ph = m_ph + 1;
    end
  end

  function automatic logic [20:0] model_vec();
    logic [7:0] r0, r1;
    r0 = m_rem[0][7:0];
    r1 = m_rem[1][7:0];
    return {m_ft, m_run[1], m_run[0], m_to[1], m_to[0], r1, r0};
  endfunction

  task automatic test_reset();
    int first, second;
    bit idle_bad;
    resetn = 1'b0;
    @(negedge clk); @(negedge clk);
    n_checks++;
    if (act !== 21'd0) begin n_fail++; $display("FAIL reset_outputs got %h want 0", act); end
    resetn = 1'b1;
    first = -1; second = -1; idle_bad = 1'b0;
    for (int k = 1; k <= 35; k++) begin
      @(negedge clk);
      n_checks++;
      if (act !== model_vec()) begin n_fail++; $display("FAIL reset_model cyc %0d got %h want %h", k, act, model_vec()); end
      if (frame_tick) begin
        if (first < 0) first = k;
        else if (second < 0) second = k;
      end
      if (busy !== 2'b00 || timeout !== 2'b00 || remaining !== 16'd0) idle_bad = 1'b1;
    end
    n_checks++;
    if (first != 10) begin n_fail++; $display("FAIL tick_first got %0d want 10", first); end
    n_checks++;
    if (second - first != 10) begin n_fail++; $display("FAIL tick_period got %0d want 10", second - first); end
    n_checks++;
    if (idle_bad) begin n_fail++; $display("FAIL idle_outputs got nonzero want 0"); end
  endtask

  task automatic test_oneshot();
    int ticks;
    bit seen_to, last_ft;
    @(negedge clk);
    load_val[7:0] = 8'd3; periodic[0] = 1'b0; start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    n_checks++;
    if (busy[0] !== 1'b1 || remaining[7:0] !== 8'd3) begin
      n_fail++; $display("FAIL oneshot_load got busy=%b rem=%0d want busy=1 rem=3", busy[0], remaining[7:0]);
    end
    ticks = 0; seen_to = 1'b0; last_ft = 1'b0;
    for (int k = 0; k < 60 && !seen_to; k++) begin
      n_checks++;
      if (act !== model_vec()) begin n_fail++; $display("FAIL oneshot_model cyc %0d got %h want %h", k, act, model_vec()); end
      if (timeout[0]) seen_to = 1'b1;
      else begin
        if (frame_tick) ticks++;
        last_ft = frame_tick;
        @(negedge clk);
      end
    end
    n_checks++;
    if (!seen_to || ticks != 3 || !last_ft) begin
      n_fail++; $display("FAIL oneshot_expiry got seen=%0b ticks=%0d lastft=%0b want 1/3/1", seen_to, ticks, last_ft);
    end
    n_checks++;
    if (busy[0] !== 1'b0 || remaining[7:0] !== 8'd0) begin
      n_fail++; $display("FAIL oneshot_idle got busy=%b rem=%0d want 0/0", busy[0], remaining[7:0]);
    end
  endtask

  task automatic test_periodic();
    int n_to, last;
    bit late_to;
    @(negedge clk);
    load_val[15:8] = 8'd2; periodic[1] = 1'b1; start[1] = 1'b1;
    @(negedge clk);
    start[1] = 1'b0;
    n_to = 0; last = -1;
    for (int k = 0; k < 75; k++) begin
      n_checks++;
      if (act !== model_vec()) begin n_fail++; $display("FAIL periodic_model cyc %0d got %h want %h", k, act, model_vec()); end
      if (timeout[1]) begin
        if (last >= 0) begin
          n_checks++;
          if (k - last != 20) begin n_fail++; $display("FAIL periodic_interval got %0d want 20", k - last); end
        end
        last = k; n_to++;
      end
      @(negedge clk);
    end
    n_checks++;
    if (n_to < 3) begin n_fail++; $display("FAIL periodic_count got %0d want >=3", n_to); end
    clear[1] = 1'b1;
    @(negedge clk);
    clear[1] = 1'b0;
    n_checks++;
    if (busy[1] !== 1'b0 || remaining[15:8] !== 8'd0) begin
      n_fail++; $display("FAIL periodic_clear got busy=%b rem=%0d want 0/0", busy[1], remaining[15:8]);
    end
    late_to = 1'b0;
    for (int k = 0; k < 45; k++) begin
      @(negedge clk);
      n_checks++;
      if (act !== model_vec()) begin n_fail++; $display("FAIL cleared_model cyc %0d got %h want %h", k, act, model_vec()); end
      if (timeout[1]) late_to = 1'b1;
    end
    n_checks++;
    if (late_to) begin n_fail++; $display("FAIL cleared_timeout got 1 want 0"); end
    periodic[1] = 1'b0;
  endtask

  task automatic test_stop_restart();
    bit got, bad, seen_to, last_ft;
    int ticks;
    @(negedge clk);
    load_val[7:0] = 8'd3; periodic[0] = 1'b0; start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 30 && !got; k++) begin
      n_checks++;
      if (act !== model_vec()) begin n_fail++; $display("FAIL stop_model cyc %0d got %h want %h", k, act, model_vec()); end
      if (frame_tick) got = 1'b1;
      @(negedge clk);
    end
    n_checks++;
    if (!got || remaining[7:0] !== 8'd2) begin
      n_fail++; $display("FAIL stop_first_tick got tick=%0b rem=%0d want 1/2", got, remaining[7:0]);
    end
    stop[0] = 1'b1;
    @(negedge clk);
    stop[0] = 1'b0;
    bad = 1'b0;
    for (int k = 0; k < 35; k++) begin
      n_checks++;
      if (act !== model_vec()) begin n_fail++; $display("FAIL stop_hold_model cyc %0d got %h want %h", k, act, model_vec()); end
      if (remaining[7:0] !== 8'd2 || timeout[0] !== 1'b0 || busy[0] !== 1'b0) bad = 1'b1;
      @(negedge clk);
    end
    n_checks++;
    if (bad) begin n_fail++; $display("FAIL stop_hold got rem=%0d busy=%b want rem=2 held idle", remaining[7:0], busy[0]); end
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    n_checks++;
    if (remaining[7:0] !== 8'd3 || busy[0] !== 1'b1) begin
      n_fail++; $display("FAIL restart_load got rem=%0d busy=%b want 3/1", remaining[7:0], busy[0]);
    end
    ticks = 0; seen_to = 1'b0; last_ft = 1'b0;
    for (int k = 0; k < 60 && !seen_to; k++) begin
      n_checks++;
      if (act !== model_vec()) begin n_fail++; $display("FAIL restart_model cyc %0d got %h want %h", k, act, model_vec()); end
      if (timeout[0]) seen_to = 1'b1;
      else begin
        if (frame_tick) ticks++;
        last_ft = frame_tick;
        @(negedge clk);
      end
    end
    n_checks++;
    if (!seen_to || ticks != 3 || !last_ft) begin
      n_fail++; $display("FAIL restart_expiry got seen=%0b ticks=%0d want 1/3", seen_to, ticks);
    end
  endtask

  task automatic test_priority_zero();
    @(negedge clk);
    load_val[7:0] = 8'd5; start[0] = 1'b1;
    @(negedge clk);
    clear[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0; clear[0] = 1'b0;
    n_checks++;
    if (busy[0] !== 1'b0 || remaining[7:0] !== 8'd0 || timeout[0] !== 1'b0) begin
      n_fail++; $display("FAIL clear_wins got busy=%b rem=%0d to=%b want 0/0/0", busy[0], remaining[7:0], timeout[0]);
    end
    load_val[15:8] = 8'd0; start[1] = 1'b1;
    @(negedge clk);
    start[1] = 1'b0;
    n_checks++;
    if (timeout[1] !== 1'b1 || busy[1] !== 1'b0 || remaining[15:8] !== 8'd0) begin
      n_fail++; $display("FAIL zero_load_pulse got to=%b busy=%b rem=%0d want 1/0/0", timeout[1], busy[1], remaining[15:8]);
    end
    @(negedge clk);
    n_checks++;
    if (timeout[1] !== 1'b0) begin n_fail++; $display("FAIL zero_load_single got to=%b want 0", timeout[1]); end
    n_checks++;
    if (act !== model_vec()) begin n_fail++; $display("FAIL priority_model got %h want %h", act, model_vec()); end
  endtask

  task automatic test_reset_midrun();
    bit got, bad;
    @(negedge clk);
    load_val[7:0] = 8'd7; periodic[0] = 1'b0; start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 60 && !got; k++) begin
      n_checks++;
      if (act !== model_vec()) begin n_fail++; $display("FAIL midrun_model cyc %0d got %h want %h", k, act, model_vec()); end
      if (remaining[7:0] == 8'd5) got = 1'b1;
      else @(negedge clk);
    end
    n_checks++;
    if (!got) begin n_fail++; $display("FAIL midrun_reach got rem=%0d want 5", remaining[7:0]); end
    resetn = 1'b0;
    #1;
    n_checks++;
    if (act !== 21'd0) begin n_fail++; $display("FAIL midrun_async got %h want 0", act); end
    bad = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (act !== 21'd0) bad = 1'b1;
    end
    n_checks++;
    if (bad) begin n_fail++; $display("FAIL midrun_held got %h want 0", act); end
    resetn = 1'b1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      n_checks++;
      if (act !== model_vec()) begin n_fail++; $display("FAIL post_reset_model cyc %0d got %h want %h", k, act, model_vec()); end
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 1500; k++) begin
      @(negedge clk);
      n_checks++;
      if (act !== model_vec()) begin n_fail++; $display("FAIL random_model cyc %0d got %h want %h", k, act, model_vec()); end
      for (int c = 0; c < CH; c++) begin
        start[c]    = ($urandom_range(0, 39) == 0);
        stop[c]     = ($urandom_range(0, 79) == 0);
        clear[c]    = ($urandom_range(0, 119) == 0);
        periodic[c] = ($urandom_range(0, 1) == 1);
        load_val[c*W +: W] = 8'($urandom_range(0, 4));
      end
`ifdef GAME_TIMER_PAUSE_EN
      if ($urandom_range(0, 19) == 0) pause = ~pause;
`endif
    end
    @(negedge clk);
    start = '0; stop = '0; clear = '0; periodic = '0;
`ifdef GAME_TIMER_PAUSE_EN
    pause = 1'b0;
`endif
  endtask

`ifdef GAME_TIMER_PAUSE_EN
  task automatic test_pause();
    int t [2];
    bit got, seen_to;
    for (int r = 0; r < 2; r++) begin
      @(negedge clk);
      clear = '1;
      @(negedge clk);
      clear = '0;
      got = 1'b0;
      for (int k = 0; k < 30 && !got; k++) begin
        @(negedge clk);
        if (frame_tick) got = 1'b1;
      end
      load_val[7:0] = 8'd3; periodic[0] = 1'b0; start[0] = 1'b1;
      @(negedge clk);
      start[0] = 1'b0;
      t[r] = -1; seen_to = 1'b0;
      for (int k = 1; k < 120 && !seen_to; k++) begin
        if (r == 1 && k == 5) pause = 1'b1;
        if (r == 1 && k == 30) pause = 1'b0;
        @(negedge clk);
        n_checks++;
        if (act !== model_vec()) begin n_fail++; $display("FAIL pause_model cyc %0d got %h want %h", k, act, model_vec()); end
        if (timeout[0]) begin seen_to = 1'b1; t[r] = k; end
      end
      pause = 1'b0;
    end
    n_checks++;
    if (t[0] < 0 || t[1] != t[0] + 25) begin
      n_fail++; $display("FAIL pause_delay got %0d want %0d", t[1], t[0] + 25);
    end
  endtask
`endif

  initial begin
    #1000000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_oneshot();
    test_periodic();
    test_stop_restart();
    test_priority_zero();
    test_reset_midrun();
    test_random();
`ifdef GAME_TIMER_PAUSE_EN
    test_pause();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
